// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by both the TX and RX blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MAX_DATA_WIDTH = 9;

  // Narrower words are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] word, input parity_t par);
    case (par)
      PAR_EVEN: return ^word;
      PAR_ODD:  return ~^word;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: rdata is valid whenever !empty, level updates one cycle after push/pop.
// Backpressure: push ignored when full, pop ignored when empty; a same-edge pop never frees a slot for that push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: start bit on sig one cycle after the accepting edge when idle, frames back-to-back.
// Backpressure: ready = FIFO not full; a word popped for the wire does not free its slot until the next edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      DATA_WIDTH = 8,
  parameter int      BAUD_RATE  = 9600,
  parameter int      CLK_FREQ   = 12_000_000,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             data,
  input  logic                              valid,
  output logic                              ready,
  output logic                              sig,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W      = $clog2(PULSE_WIDTH);
  localparam int BIT_W       = $clog2(DATA_WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_WIDTH - 1);
  localparam logic              STOP_RELOAD = (STOP_BITS == 2);

  if (PULSE_WIDTH < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter set");
  end

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_r;
  logic                  sig_nxt;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  bit_done;
  logic                  last_data;
  logic                  last_stop;

  assign push      = valid && ready;
  assign ready     = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_level != '0);
  assign bit_done  = (baud_cnt == '0);
  assign last_data = (bit_cnt == BIT_LAST);
  assign last_stop = bit_done && !stop_cnt;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (!fifo_empty) state_nxt = START;
      START:            if (bit_done) state_nxt = DATA;
      DATA:             if (bit_done && last_data)
                          state_nxt = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
      uart_pkg::PARITY: if (bit_done) state_nxt = STOP;
      STOP:             if (last_stop) state_nxt = fifo_empty ? IDLE : START;
      default:          state_nxt = IDLE;
    endcase
  end

  // sig_nxt is the value the line takes after this edge; sig itself is always a flop.
  always_comb begin
    pop     = 1'b0;
    sig_nxt = sig;
    case (state)
      IDLE: begin
        pop     = !fifo_empty;
        sig_nxt = fifo_empty;
      end
      START:            if (bit_done) sig_nxt = shift[0];
      DATA:             if (bit_done)
                          sig_nxt = last_data ? ((PARITY == PAR_NONE) ? 1'b1 : par_r) : shift[0];
      uart_pkg::PARITY: if (bit_done) sig_nxt = 1'b1;
      STOP: if (last_stop) begin
        pop     = !fifo_empty;
        sig_nxt = fifo_empty;
      end
      default:          sig_nxt = 1'b1;
    endcase
  end

  // shift[0] always holds the next data bit to drive, so it shifts as each bit is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_r    <= 1'b0;
    end else begin
      sig <= sig_nxt;
      if (pop) begin
        shift    <= fifo_rdata;
        par_r    <= parity_bit(MAX_DATA_WIDTH'(fifo_rdata), PARITY);
        baud_cnt <= BAUD_RELOAD;
        bit_cnt  <= '0;
        stop_cnt <= STOP_RELOAD;
      end else if (state != IDLE) begin
        baud_cnt <= bit_done ? BAUD_RELOAD : baud_cnt - 1'b1;
        if (bit_done) begin
          if (state == START || (state == DATA && !last_data)) shift <= shift >> 1;
          if (state == DATA && !last_data) bit_cnt <= bit_cnt + 1'b1;
          if (state == STOP && stop_cnt) stop_cnt <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: seven parameter sets side by side, each watched by a bit-level UART receiver
// that checks every frame against the words the bench pushed.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int NCFG = 7;
  localparam int PW   = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       data  [NCFG];
  logic [NCFG-1:0]  valid;
  logic [NCFG-1:0]  ready;
  logic [NCFG-1:0]  sig;
  logic [NCFG-1:0]  busy;
  logic [4:0]       lvl   [NCFG];

  int               cyc    = 0;
  int               n_vec  = 0;
  int               n_err  = 0;
  int               peak6  = 0;
  logic [7:0]       exp_q   [NCFG][$];
  int               start_q [NCFG][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (int'(lvl[6]) > peak6) peak6 <= int'(lvl[6]);

  function automatic parity_t cfg_par(input int g);
    if (g == 1 || g == 4) return PAR_EVEN;
    if (g == 2 || g == 5) return PAR_ODD;
    return PAR_NONE;
  endfunction

  function automatic int cfg_sb(input int g);
    return (g >= 3 && g <= 5) ? 2 : 1;
  endfunction

  // Parity bit that makes the total count of ones even (EVEN) or odd (ODD).
  function automatic logic exp_par(input logic [7:0] w, input parity_t p);
    int ones;
    ones = $countones(w);
    return (p == PAR_EVEN) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  generate
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam parity_t P  = cfg_par(g);
      localparam int      SB = cfg_sb(g);
      localparam int      FD = (g == 6) ? 4 : 16;
      localparam int      LW = $clog2(FD + 1);
      localparam int      NB = 9 + ((P != PAR_NONE) ? 1 : 0) + SB;

      logic [LW-1:0] lv;
      assign lvl[g] = 5'(lv);

      uart_tx_fifo #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (1_000_000),
        .CLK_FREQ   (12_000_000),
        .PARITY     (P),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (FD)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data[g]),
        .valid      (valid[g]),
        .ready      (ready[g]),
        .sig        (sig[g]),
        .busy       (busy[g]),
        .fifo_level (lv)
      );

      // Receiver: samples every cycle of every bit period, rejects frames cut short by reset.
      initial begin : rx_model
        logic [11:0] bv;
        logic [11:0] ef;
        logic [7:0]  w;
        logic        aborted;
        logic        glitch;
        int          t0;
        int          k;
        forever begin
          @(negedge clk);
          if (rst !== 1'b0 || sig[g] !== 1'b0) continue;
          t0      = cyc;
          bv      = '0;
          aborted = 1'b0;
          glitch  = 1'b0;
          for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < PW; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst !== 1'b0)     aborted = 1'b1;
              else if (c == 0)      bv[b] = sig[g];
              else if (sig[g] !== bv[b]) glitch = 1'b1;
            end
          end
          if (!aborted) begin
            start_q[g].push_back(t0);
            chk($sformatf("rx_glitch_cfg%0d", g), int'(glitch), 0);
            if (exp_q[g].size() == 0) begin
              chk($sformatf("rx_unexpected_frame_cfg%0d", g), exp_q[g].size(), 1);
            end else begin
              w  = exp_q[g].pop_front();
              ef = '0;
              ef[8:1] = w;
              k = 9;
              if (P != PAR_NONE) begin
                ef[k] = exp_par(w, P);
                k++;
              end
              for (int s = 0; s < SB; s++) ef[k+s] = 1'b1;
              chk($sformatf("rx_frame_cfg%0d", g), int'(bv), int'(ef));
            end
          end
        end
      end
    end
  endgenerate

  // Present w from a negedge until accepted; hs is the cycle number of the accepting edge.
  task automatic push_word(input int g, input logic [7:0] w, output int hs);
    int n;
    n = 0;
    hs = -1;
    @(negedge clk);
    data[g]  = w;
    valid[g] = 1'b1;
    while (!ready[g] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready[g]) begin
      chk($sformatf("push_timeout_cfg%0d", g), int'(ready[g]), 1);
      valid[g] = 1'b0;
    end else begin
      hs = cyc + 1;
      exp_q[g].push_back(w);
      @(posedge clk);
      #1 valid[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int g, output int t);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[g] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (busy[g]) chk($sformatf("idle_timeout_cfg%0d", g), int'(busy[g]), 0);
  endtask

  task automatic drive_rand(input int g, input int nwords);
    int h;
    int t;
    for (int i = 0; i < nwords; i++) begin
      if ($urandom_range(0, 24) == 0) wait_idle(g, t);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      push_word(g, 8'($urandom), h);
    end
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached, expected completion before 90000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, t, x, low_seen;
    int hs6 [6];

    rst   = 1'b1;
    valid = '0;
    for (int g = 0; g < NCFG; g++) data[g] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sig",    int'(sig),    7'h7f);
    chk("rst_ready",  int'(ready),  7'h7f);
    chk("rst_busy",   int'(busy),   0);
    chk("rst_level0", int'(lvl[0]), 0);
    chk("rst_level6", int'(lvl[6]), 0);
    rst = 1'b0;

    // Single 8N1 frame: start one cycle after acceptance, 120-cycle frame.
    push_word(0, 8'hA5, h);
    @(negedge clk);
    chk("t1_line_idle_at_accept", int'(sig[0]), 1);
    @(negedge clk);
    chk("t1_start_latency", int'(sig[0]), 0);
    chk("t1_busy", int'(busy[0]), 1);
    wait_idle(0, t);
    chk("t1_frame_len", t - (h + 1), 120);

    // Even and odd parity frames.
    fork
      begin : b_even
        int h1, t1;
        push_word(1, 8'hA5, h1);
        wait_idle(1, t1);
        chk("t2_even_frame_len", t1 - (h1 + 1), 132);
      end
      begin : b_odd
        int h2, t2;
        push_word(2, 8'hA5, h2);
        wait_idle(2, t2);
        chk("t2_odd_frame_len", t2 - (h2 + 1), 132);
      end
    join

    // Two stop bits, back-to-back frames with no idle gap.
    push_word(3, 8'h00, h);
    push_word(3, 8'hFF, x);
    chk("t3_b2b_accept", x - h, 1);
    wait_idle(3, t);
    chk("t3_frames_seen", start_q[3].size(), 2);
    chk("t3_first_start", start_q[3][0], h + 1);
    chk("t3_second_start", start_q[3][1] - start_q[3][0], 132);
    chk("t3_total_len", t - (h + 1), 264);

    // Depth-4 FIFO filled while one word is on the wire.
    for (int i = 0; i < 5; i++) push_word(6, 8'(8'h10 + i), hs6[i]);
    @(negedge clk);
    chk("t4_ready_when_full", int'(ready[6]), 0);
    chk("t4_level_when_full", int'(lvl[6]), 4);
    push_word(6, 8'h15, hs6[5]);
    chk("t4_fill_no_stall", hs6[4] - hs6[0], 4);
    chk("t4_stall_release", hs6[5] - hs6[0], 122);
    wait_idle(6, t);
    chk("t4_peak_level", peak6, 4);

    // Push on the very edge that pops the next word: level holds at 2.
    push_word(0, 8'h5A, h);
    push_word(0, 8'hC3, x);
    push_word(0, 8'h81, x);
    do @(negedge clk); while (cyc < h + 120);
    chk("t5_level_before", int'(lvl[0]), 2);
    data[0]  = 8'h3E;
    valid[0] = 1'b1;
    exp_q[0].push_back(8'h3E);
    @(posedge clk);
    #1 valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_level_same_edge", int'(lvl[0]), 2);
    chk("t5_next_start", int'(sig[0]), 0);
    wait_idle(0, t);

    // Reset in the middle of a data bit with two words still queued.
    push_word(0, 8'h3C, h);
    push_word(0, 8'h11, x);
    push_word(0, 8'h22, x);
    do @(negedge clk); while (cyc < h + 1 + 3 * PW + 5);
    chk("t6_pre_level", int'(lvl[0]), 2);
    chk("t6_pre_busy", int'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_sig", int'(sig[0]), 1);
    chk("t6_rst_ready", int'(ready[0]), 1);
    chk("t6_rst_level", int'(lvl[0]), 0);
    chk("t6_rst_busy", int'(busy[0]), 0);
    for (int g = 0; g < NCFG; g++) exp_q[g].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    low_seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (!sig[0]) low_seen++;
    end
    chk("t6_no_frame_after_release", low_seen, 0);
    chk("t6_idle_after_release", int'(busy[0]), 0);

    // Random words through every parity / stop-bit combination.
    fork
      drive_rand(0, 167);
      drive_rand(1, 167);
      drive_rand(2, 167);
      drive_rand(3, 167);
      drive_rand(4, 167);
      drive_rand(5, 167);
    join
    for (int g = 0; g < NCFG; g++) begin
      wait_idle(g, t);
      chk($sformatf("t7_all_words_received_cfg%0d", g), exp_q[g].size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
